pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
Parametrised, pipelined add/subtract unit. Splits a WIDTH-bit operation into WIDTH/CHUNK chunk stages, with one register stage per chunk and the carry passed stage-to-stage. Operands enter and results leave on a valid/ready handshake with full backpressure. This is the clocked, throughput-oriented successor to the team's combinational ripple adders, used wherever wide arithmetic must close timing at one result per cycle.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK (elaboration error otherwise)
CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit accepts beat this cycle
ain  input  WIDTH  operand A
bin  input  WIDTH  operand B
cin  input  1  carry-in (add mode) / borrow-in (sub mode)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result
cout  output  1  carry-out (add) / not-borrow (sub)
ovf  output  1  two's-complement signed overflow

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Reset (async assert, sync release): all stage valid bits 0, all data/carry registers 0; out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 whenever rst_n=1 and the pipe is empty.
- Arithmetic: add: {cout,sum} = ain + bin + cin. Sub: sum = ain - bin - cin, implemented as ain + ~bin + !cin; cout=1 means no borrow. All results are modulo 2^WIDTH.
- ovf = carry into MSB XOR carry out of MSB of the final stage. It applies in both modes.
- Pipeline: stage k (0..STAGES-1) adds chunk k of the operands plus the carry from stage k-1. Stage 0 takes carry-in (cin or !cin). Higher chunks of A and effective-B are carried forward in skew registers. Completed low chunks are carried forward to assemble sum.
- Global advance: adv = !out_valid || out_ready. in_ready = adv. A beat is accepted when in_valid && in_ready.
- When adv=1, every stage register loads from its predecessor. Stage 0 valid loads in_valid. When adv=0, the whole pipe holds.
- Bubbles are not collapsed.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles from acceptance to the result becoming visible. Throughput: 1 beat/cycle when out_ready=1.
- Outputs are registered (last stage). sum, cout and ovf are stable while out_valid && !out_ready.
- sub, cin, ain and bin are sampled only on acceptance. Changes while in_ready=0 have no effect.
- Simultaneous accept and deliver in one cycle is legal and loses nothing.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (async). No partial result is ever presented.
- STAGES=1: single registered adder, latency 1.

Decomposition:
- Package adder_pkg: function for STAGES computation, a localparam check helper, and a typedef for the chunk stage record (valid, carry, partial sum, remaining A/B).
- Sub-module adder_chunk: combinational CHUNK-bit adder with carry in/out and carry-into-MSB output. It is used once per stage via generate. The top instantiates the stage registers and handshake logic.

Test Plan:
- Defaults, add, 0xFFFFFFFF + 0x00000001, cin=0, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, ovf=0.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1. Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Sub 5 - 7, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Sub 7 - 5 with cin=1 -> sum=1, cout=1.
- Stream 8 random beats back-to-back. Hold out_ready=0 after 2 results for 5 cycles -> in_ready=0 while stalled, outputs stable, all 8 results in order and matching the reference model, no drops or duplicates.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 and sum=0 immediately. After release, a new beat 1+2 yields sum=3 with latency 4 and no stale data.
- WIDTH=8, CHUNK=4 instance: exhaustive 256x256x2x2 sweep -> matches {cout,sum} model. Latency 2.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: stage count
// derivation, parameter legality check and the per-stage control record.
package adder_pkg;

    // Control half of a pipeline stage record. The data half (partial sum and
    // remaining operand chunks) changes width from stage to stage, so it is
    // kept as per-stage vectors in the top rather than in this record.
    typedef struct packed {
        logic valid;  // this stage holds a live beat
        logic carry;  // carry out of the chunk this stage just added
    } stage_ctl_t;

    // Number of chunk stages for a WIDTH-bit operation split into CHUNK bits.
    function automatic int stages_f(input int width, input int chunk);
        return (chunk > 0) ? width / chunk : 1;
    endfunction

    // WIDTH must be a non-zero whole number of CHUNK-bit slices.
    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational W-bit adder slice. Besides the usual carry-out it exposes the
// carry into its most significant bit, which the final slice needs to derive
// two's-complement overflow.
module adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    if (W == 1) begin : g_one
        assign c_msb = ci;
        assign s     = a ^ b ^ ci;
    end else begin : g_multi
        // Low W-1 bits plus one spare bit that captures the carry into the MSB.
        logic [W-1:0] low;
        assign low        = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, ci};
        assign s[W-2:0]   = low[W-2:0];
        assign c_msb      = low[W-1];
        assign s[W-1]     = a[W-1] ^ b[W-1] ^ c_msb;
    end

    assign co = (a[W-1] & b[W-1]) | (c_msb & (a[W-1] ^ b[W-1]));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit. Each stage adds one CHUNK-bit slice
// and hands its carry to the next stage; the untouched high operand slices
// ride along in skew registers and the finished low slices accumulate into
// the result. The whole pipe advances together under a valid/ready handshake.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages_f(WIDTH, CHUNK);

    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // The pipe moves only when the output register is free or being drained;
    // bubbles travel with it rather than being squeezed out.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * CHUNK;  // operand bits not yet added, incl. this slice
        localparam int DONE = k * CHUNK;          // result bits already produced upstream

        stage_ctl_t                ctl_in;
        logic [REM-1:0]            a_in;
        logic [REM-1:0]            b_in;
        logic [DONE+CHUNK-1:0]     sum_nxt;
        logic [CHUNK-1:0]          s;
        logic                      co;
        logic                      c_msb;

        if (k == 0) begin : g_src
            // Subtraction is ain + ~bin + !cin, so the inversion happens once
            // here and every later stage is a plain adder.
            assign ctl_in  = '{valid: in_valid, carry: sub ? ~cin : cin};
            assign a_in    = ain;
            assign b_in    = sub ? ~bin : bin;
            assign sum_nxt = s;
        end else begin : g_link
            assign ctl_in  = g_stage[k-1].g_reg.ctl_q;
            assign a_in    = g_stage[k-1].g_reg.a_q;
            assign b_in    = g_stage[k-1].g_reg.b_q;
            assign sum_nxt = {s, g_stage[k-1].g_reg.sum_q};
        end

        adder_chunk #(.W(CHUNK)) u_chunk (
            .a     (a_in[CHUNK-1:0]),
            .b     (b_in[CHUNK-1:0]),
            .ci    (ctl_in.carry),
            .s     (s),
            .co    (co),
            .c_msb (c_msb)
        );

        if (k < STAGES - 1) begin : g_reg
            stage_ctl_t              ctl_q;
            logic [REM-CHUNK-1:0]    a_q;
            logic [REM-CHUNK-1:0]    b_q;
            logic [DONE+CHUNK-1:0]   sum_q;

            // Carry-into-MSB only matters for the most significant slice.
            logic unused_c_msb;
            assign unused_c_msb = c_msb;

            // Intermediate stage register: capture this slice's result, pass
            // the remaining operand slices on, or hold while the pipe stalls.
            // NOTE: data registers are reset as well as valid, so nothing left
            // over from before a reset can ever be assembled into a result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ctl_q <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                end else if (adv) begin
                    // NOTE: non-blocking so every stage samples its
                    // predecessor's value from before this clock edge.
                    ctl_q <= '{valid: ctl_in.valid, carry: co};
                    a_q   <= a_in[REM-1:CHUNK];
                    b_q   <= b_in[REM-1:CHUNK];
                    sum_q <= sum_nxt;
                end
            end
        end else begin : g_out
            // Output register: the final slice completes the result and the
            // overflow flag; held unchanged while downstream is not ready.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= ctl_in.valid;
                    sum       <= sum_nxt;
                    cout      <= co;
                    ovf       <= c_msb ^ co;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases, a randomized stream with
// a downstream stall, mid-flight reset, and an exhaustive sweep of a narrow
// WIDTH=8/CHUNK=4 configuration spread over parallel instances.
module tb_pipelined_adder;

    localparam int STG = 4;     // stages of the 32-bit instance
    localparam int NS  = 16;    // parallel 8-bit instances for the sweep
    localparam int NB  = 16384; // beats per 8-bit instance (64 a-values x 256 b-values)

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] ain, bin, sum;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ain       (ain),
        .bin       (bin),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    logic       e_in_valid;
    logic [7:0] e_a [NS];
    logic [7:0] e_b [NS];
    logic [7:0] e_sum [NS];
    logic       e_cin [NS];
    logic       e_sub [NS];
    logic       e_in_ready [NS];
    logic       e_out_valid [NS];
    logic       e_cout [NS];
    logic       e_ovf [NS];

    for (genvar g = 0; g < NS; g++) begin : g_small
        pipelined_adder #(.WIDTH(8), .CHUNK(4)) u_small (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (e_in_valid),
            .in_ready  (e_in_ready[g]),
            .ain       (e_a[g]),
            .bin       (e_b[g]),
            .cin       (e_cin[g]),
            .sub       (e_sub[g]),
            .out_valid (e_out_valid[g]),
            .out_ready (1'b1),
            .sum       (e_sum[g]),
            .cout      (e_cout[g]),
            .ovf       (e_ovf[g])
        );
    end

    // Reference: exact integer arithmetic. Returns {ovf, cout, sum[63:0]}.
    // cout for subtraction means "no borrow", i.e. a >= b + c.
    // ovf means the exact signed result does not fit in w bits.
    function automatic logic [65:0] model(input int w, input longint unsigned a,
                                          input longint unsigned b, input bit c, input bit s);
        longint unsigned mask, ur;
        longint          sa, sb, r, lim;
        bit              co, ov;
        mask = (64'd1 << w) - 64'd1;
        lim  = longint'(64'd1 << (w - 1));
        sa   = (((a >> (w - 1)) & 64'd1) != 0) ? longint'(a) - 2 * lim : longint'(a);
        sb   = (((b >> (w - 1)) & 64'd1) != 0) ? longint'(b) - 2 * lim : longint'(b);
        if (s) begin
            co = (a >= b + 64'(c));
            ur = a - b - 64'(c);
            r  = sa - sb - longint'(c);
        end else begin
            ur = a + b + 64'(c);
            co = ((ur >> w) & 64'd1) != 0;
            r  = sa + sb + longint'(c);
        end
        ov = (r >= lim) || (r < -lim);
        return {ov, co, ur & mask};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat on the 32-bit instance; entered at posedge+1 with an
    // empty pipe and out_ready=1, leaves at posedge+1 with the pipe drained.
    task automatic send_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic c, input logic s, input logic [31:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf);
        int lat;
        ain = a; bin = b; cin = c; sub = s; in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        // Scramble operands after acceptance: they must not leak into the beat.
        in_valid = 1'b0; ain = $urandom; bin = $urandom;
        cin = 1'($urandom); sub = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(STG));
        check({tag, " sum"},     64'(sum),  64'(exp_sum));
        check({tag, " cout"},    64'(cout), 64'(exp_cout));
        check({tag, " ovf"},     64'(ovf),  64'(exp_ovf));
        @(posedge clk); #1;
        check({tag, " drained"}, 64'(out_valid), 64'd0);
    endtask

    logic [33:0] exp_q [$];

    initial begin
        int          sent, got, stall, cyc, lat;
        logic [31:0] ca, cb;
        logic        cc, cs;
        logic [65:0] m;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ain = '0; bin = '0; cin = 1'b0; sub = 1'b0;
        e_in_valid = 1'b0;
        for (int g = 0; g < NS; g++) begin
            e_a[g] = '0; e_b[g] = '0; e_cin[g] = 1'b0; e_sub[g] = 1'b0;
        end

        // Reset state.
        #3;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset sum",       64'(sum),       64'd0);
        check("reset cout",      64'(cout),      64'd0);
        check("reset ovf",       64'(ovf),       64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases.
        send_one("add wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        send_one("add pos ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        send_one("sub neg ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        send_one("sub 5-7",         32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        send_one("sub 7-5-1",       32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        send_one("add cin chain",   32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
        send_one("add ones cin",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send_one("sub 0-0-1",       32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Random stream of 8 beats with a 5-cycle downstream stall after 2 results.
        sent = 0; got = 0; stall = 0; cyc = 0;
        ca = $urandom; cb = $urandom; cc = 1'($urandom); cs = 1'($urandom);
        while (got < 8 && cyc < 200) begin
            if (got >= 2 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (sent < 8);
            #1;
            if (in_ready) begin
                ain = ca; bin = cb; cin = cc; sub = cs;
            end else begin
                ain = $urandom; bin = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            end
            if (!out_ready && out_valid)
                check("stall in_ready", 64'(in_ready), 64'd0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stream spurious", 64'(out_valid), 64'd0);
                end else begin
                    check($sformatf("stream result %0d", got), 64'({ovf, cout, sum}), 64'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = model(32, 64'(ca), 64'(cb), cc, cs);
                exp_q.push_back({m[65], m[64], m[31:0]});
                sent++;
                ca = $urandom; cb = $urandom; cc = 1'($urandom); cs = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream delivered", 64'(got),          64'd8);
        check("stream accepted",  64'(sent),         64'd8);
        check("stream leftover",  64'(exp_q.size()), 64'd0);
        check("stream idle",      64'(out_valid),    64'd0);

        // Reset with beats in flight and the output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ain = 32'h1234_5678 + 32'(i); bin = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("pre-reset valid", 64'(out_valid), 64'd1);
        check("pre-reset sum",   64'(sum),       64'h2345_6789);
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset sum",       64'(sum),       64'd0);
        check("async reset cout",      64'(cout),      64'd0);
        check("async reset in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post-reset idle", 64'(out_valid), 64'd0);
        end
        send_one("after reset", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);

        // Exhaustive WIDTH=8/CHUNK=4 sweep: instance g covers sub=g[3], cin=g[2]
        // and a in [64*g[1:0], 64*g[1:0]+63]; one beat per cycle, latency 2.
        for (int n = 0; n < NB + 2; n++) begin
            e_in_valid = (n < NB);
            for (int g = 0; g < NS; g++) begin
                e_a[g]   = 8'((g % 4) * 64 + n / 256);
                e_b[g]   = 8'(n % 256);
                e_cin[g] = 1'((g >> 2) & 1);
                e_sub[g] = 1'((g >> 3) & 1);
            end
            for (int g = 0; g < NS; g++) begin
                if (n >= 2) begin
                    int k;
                    logic [65:0] x;
                    k = n - 2;
                    x = model(8, 64'((g % 4) * 64 + k / 256), 64'(k % 256),
                              bit'((g >> 2) & 1), bit'((g >> 3) & 1));
                    check($sformatf("sweep g%0d beat%0d", g, k),
                          {52'b0, e_in_ready[g], e_out_valid[g], e_ovf[g], e_cout[g], e_sum[g]},
                          {52'b0, 1'b1, 1'b1, x[65], x[64], x[7:0]});
                end else begin
                    check($sformatf("sweep g%0d fill", g), 64'(e_out_valid[g]), 64'd0);
                end
            end
            @(posedge clk); #1;
        end
        check("sweep drained", 64'(e_out_valid[0]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
